// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the dual-clock fifo (slave side) and its UART
// consumer (master side).
interface fifo_uart_tx_if #(
  parameter int DATA_LEN = 8
);
  // Handshake: o_fifo_read is a single-cycle strobe with no ready/back-pressure;
  // the consumer only raises it while i_fifo_empty_n is high, and the FIFO
  // answers with i_fifo_data / i_fifo_read_error valid the cycle after.
  logic                i_fifo_empty_n;
  logic [DATA_LEN-1:0] i_fifo_data;
  logic                i_fifo_read_error;
  logic                o_fifo_read;

  modport master (
    input  i_fifo_empty_n,
    input  i_fifo_data,
    input  i_fifo_read_error,
    output o_fifo_read
  );

  modport slave (
    output i_fifo_empty_n,
    output i_fifo_data,
    output i_fifo_read_error,
    input  o_fifo_read
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains bytes from the fifo read port and sends them as 8N1 UART frames,
// LSB first, entirely in the read clock domain. All outputs are registered.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_LEN     = 8
) (
  input  logic           i_clk_read,
  input  logic           i_reset,
  input  logic           i_enable,
  fifo_uart_tx_if.master fifo,
  output logic           o_tx,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_underrun,
  output logic [2:0]     o_state
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_LEN + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
    STOP    = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DATA_LEN-1:0] shift, shift_nxt;
  logic                tx_nxt, read_nxt, busy_nxt, done_nxt, underrun_nxt;
  logic                baud_last;

  assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign o_state   = state;

  always_ff @(posedge i_clk_read) begin
    if (i_reset) begin
      state            <= IDLE;
      baud_cnt         <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      o_tx             <= 1'b1;
      fifo.o_fifo_read <= 1'b0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_underrun       <= 1'b0;
    end else begin
      state            <= state_nxt;
      baud_cnt         <= baud_nxt;
      bit_cnt          <= bit_nxt;
      shift            <= shift_nxt;
      o_tx             <= tx_nxt;
      fifo.o_fifo_read <= read_nxt;
      o_busy           <= busy_nxt;
      o_done           <= done_nxt;
      o_underrun       <= underrun_nxt;
    end
  end

  // o_tx is registered, so each branch computes the line level for the next cycle.
  always_comb begin
    state_nxt    = state;
    baud_nxt     = '0;
    bit_nxt      = bit_cnt;
    shift_nxt    = shift;
    tx_nxt       = 1'b1;
    read_nxt     = 1'b0;
    done_nxt     = 1'b0;
    underrun_nxt = o_underrun;

    case (state)
      IDLE: begin
        bit_nxt = '0;
        if (i_enable && fifo.i_fifo_empty_n) begin
          state_nxt = FETCH;
          read_nxt  = 1'b1;
        end
      end
      FETCH: state_nxt = CAPTURE;
      CAPTURE: begin
        if (fifo.i_fifo_read_error) begin
          underrun_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          shift_nxt = fifo.i_fifo_data;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (baud_last) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shift[0];
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (baud_last) begin
          shift_nxt = shift >> 1;
          if (bit_cnt == BIT_W'(DATA_LEN - 1)) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
            tx_nxt  = shift[1];
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
